membus_target: RTL

Memory-side responder for the micro-BESM external bus: the far end of the bus arbiter. Decodes the strobes the arbiter issues (astb, rd, wr, iack, atomic), latches the address, serves reads and writes from an internal 64-bit word RAM with programmable wait states, and answers interrupt-acknowledge cycles from a pending-interrupt register. Used as the bus model in simulation and as the on-chip memory target in FPGA builds.

---
 rtl/membus_target.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/membus_target.sv
// membus_target: memory-side responder for the micro-BESM external bus.
// Latches the word address on astb, serves rd/wr from an internal 64-bit RAM
// after WAIT wait states, answers iack from the pending-interrupt register
// and flags protocol errors. Optional byte parity is enabled by defining
// MEMBUS_PARITY_EN; the default build has no parity storage and perr tied 0.
module membus_target #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1,
    parameter int NIRQ   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            astb,
    input  logic            rd,
    input  logic            wr,
    input  logic            atomic,
    input  logic            iack,
    input  logic            batch,
    input  logic [63:0]     bus_din,
    output logic [63:0]     bus_dout,
    output logic            rvalid,
    output logic            wdone,
    output logic            locked,
    input  logic [NIRQ-1:0] irq_in,
    output logic [NIRQ-1:0] irq_pend,
    output logic            err,
    output logic            perr
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wbuf;
    logic              iack_q;
    logic [63:0]       mem [DEPTH];

    logic busy;
    logic wr_commit;
    logic rd_commit;
    logic iack_rise;
    logic iack_fall;
    logic proto_err;

    assign busy      = (state != IDLE);
    assign wr_commit = (state == WWAIT) && (cnt == 4'd0);
    assign rd_commit = (state == RWAIT) && (cnt == 4'd0);
    // iack is a level; answer only once, on its first cycle in IDLE
    assign iack_rise = iack && !iack_q && !busy;
    assign iack_fall = !iack && iack_q;
    assign proto_err = (rd && wr) || (busy && (astb || rd || wr)) ||
                       (astb && locked) || (iack && busy);

    // Bus FSM: strobe decode, wait-state countdown, completion pulses, lock and irq tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr     <= '0;
            wbuf     <= 64'd0;
            bus_dout <= 64'd0;
            rvalid   <= 1'b0;
            wdone    <= 1'b0;
            locked   <= 1'b0;
            irq_pend <= '0;
            err      <= 1'b0;
            iack_q   <= 1'b0;
        end else begin
            rvalid   <= 1'b0;
            wdone    <= 1'b0;
            iack_q   <= iack;
            // new requests win over the clear caused by iack falling
            irq_pend <= (iack_fall ? '0 : irq_pend) | irq_in;
            if (proto_err) err <= 1'b1;
            if (!atomic) locked <= 1'b0;

            case (state)
                IDLE: begin
                    if (astb && !locked) addr <= bus_din[ADDR_W-1:0];
                    if (iack_rise) begin
                        bus_dout <= {{(64-NIRQ){1'b0}}, irq_pend};
                        rvalid   <= 1'b1;
                    end else if (rd && !wr) begin
                        cnt   <= WAIT_CNT;
                        state <= RWAIT;
                    end else if (wr && !rd) begin
                        wbuf  <= bus_din;
                        cnt   <= WAIT_CNT;
                        state <= WWAIT;
                    end
                end
                default: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        if (batch) addr <= addr + ADDR_W'(1);
                        if (state == RWAIT) begin
                            bus_dout <= mem[addr];
                            rvalid   <= 1'b1;
                            if (atomic) locked <= 1'b1;
                        end else begin
                            wdone  <= 1'b1;
                            locked <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // RAM write port; a reset cycle never commits a pending write
    always_ff @(posedge clk) begin
        if (!reset && wr_commit) mem[addr] <= wbuf;
    end

`ifdef MEMBUS_PARITY_EN
    function automatic logic [7:0] byte_par(input logic [63:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    logic [7:0]       par_mem [DEPTH];
    // Debug hook: one bit per word, forced from simulation to corrupt stored parity bit 0
    logic [DEPTH-1:0] dbg_par_flip;
    assign dbg_par_flip = '0;

    // Parity storage, written alongside the data word
    always_ff @(posedge clk) begin
        if (!reset && wr_commit) par_mem[addr] <= byte_par(wbuf);
    end

    // Sticky parity error, checked as the read completes; data is still delivered
    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else if (rd_commit &&
                     ((par_mem[addr] ^ {7'd0, dbg_par_flip[addr]}) != byte_par(mem[addr]))) begin
            perr <= 1'b1;
        end
    end
`else
    assign perr = 1'b0;
    logic unused_rd_commit;
    assign unused_rd_commit = rd_commit;
`endif

endmodule
